// File: rtl/serial_add_pkg.sv
// Shared encodings and width bounds for the bit-serial adder controller.
// State constants are plain 2-bit localparams so older code can reuse them.
package serial_add_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int W_MIN = 1;
   localparam int W_MAX = 32;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder built on a 3-to-8 decoder of {a,b,cin}.
// Sum and carry are ORs of the decoded minterms.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic ca
);

   logic [7:0] dec;

   assign dec = 8'b1 << {a, b, cin};
   assign s   = dec[1] | dec[2] | dec[4] | dec[7];
   assign ca  = dec[3] | dec[5] | dec[6] | dec[7];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one fa_cell, LSB first, W+2 cycles per add.
// Define SERIAL_ADD_SUB_EN to add a 'sub' port for a-b (cout=1: no borrow).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic         sub,
`endif
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int CW = (W > 1) ? $clog2(W + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_sr;
   logic [W-1:0]  b_sr;
   logic [W-1:0]  sum_sr;
   logic [W-1:0]  sum_nx;
   logic [W-1:0]  ld_b;
   logic          ld_c;
   logic          carry;
   logic          s;
   logic          ca;

`ifdef SERIAL_ADD_SUB_EN
   // Two's-complement subtract: invert b and force the carry-in
   assign ld_b = sub ? ~b : b;
   assign ld_c = sub ? 1'b1 : cin;
`else
   assign ld_b = b;
   assign ld_c = cin;
`endif

   fa_cell u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (s),
      .ca  (ca)
   );

   generate
      if (W == 1) begin : g_w1
         assign sum_nx = s;
      end else begin : g_wn
         assign sum_nx = {s, sum_sr[W-1:1]};
      end
   endgenerate

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= ld_b;
                  carry <= ld_c;
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_sr <= sum_nx;
               carry  <= ca;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sum   <= sum_nx;
                  cout  <= ca;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at W=8 and W=1.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start1, cin1, a1, b1, busy1, done1, sum1, cout1;
   logic       sub8, sub1;

   int checks   = 0;
   int failures = 0;

   logic [8:0] q8[$];
   logic [1:0] q1[$];

   serial_add_ctrl #(.W(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .cin   (cin8),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub8),
`endif
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_add_ctrl #(.W(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .cin   (cin1),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub1),
`endif
      .a     (a1),
      .b     (b1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] ref8(logic [7:0] a, logic [7:0] b,
                                      logic c, logic s);
      int r;
      if (s) begin
         r = (int'(a) - int'(b)) & 255;
         return {(a >= b), r[7:0]};
      end
      r = int'(a) + int'(b) + int'(c);
      return r[8:0];
   endfunction

   // Monitors: pop one expectation per done pulse
   logic pd8 = 1'b0;
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         chk("done8_one_cycle", pd8, 1'b0);
         if (q8.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done8_unexpected sum=%0h", sum8);
         end else begin
            chk("result8", {cout8, sum8}, q8.pop_front());
         end
      end
      pd8 = (done8 === 1'b1);
   end

   logic pd1 = 1'b0;
   always @(negedge clk) begin
      if (done1 === 1'b1) begin
         chk("done1_one_cycle", pd1, 1'b0);
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done1_unexpected sum=%0h", sum1);
         end else begin
            chk("result1", {cout1, sum1}, q1.pop_front());
         end
      end
      pd1 = (done1 === 1'b1);
   end

   task automatic wait_idle8();
      int n = 0;
      while (busy8 !== 1'b0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk("idle8_timeout", 1, 0);
   endtask

   task automatic wait_done8(input int n0, output int n);
      n = n0;
      while (done8 !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic add8(logic [7:0] a, logic [7:0] b, logic c, logic s);
      int n;
      wait_idle8();
      a8 = a;
      b8 = b;
      cin8 = c;
      sub8 = s;
      start8 = 1'b1;
      q8.push_back(ref8(a, b, c, s));
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8 = $urandom;
      b8 = $urandom;
      wait_done8(0, n);
      chk("latency8", n, 8);
   endtask

   task automatic add1(logic a, logic b, logic c);
      int n = 0;
      while (busy1 !== 1'b0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      a1 = a;
      b1 = b;
      cin1 = c;
      start1 = 1'b1;
      q1.push_back(2'(int'(a) + int'(b) + int'(c)));
      @(posedge clk);
      #1;
      start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency1", n, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      start8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
      start1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0; sub1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_sum8", sum8, 0);
      chk("rst_cout8", cout8, 0);
      chk("rst_busy1", busy1, 0);
      rst = 1'b0;

      add8(8'h35, 8'h4A, 1'b0, 1'b0);
      add8(8'hFF, 8'h01, 1'b0, 1'b0);
      add8(8'hFF, 8'hFF, 1'b1, 1'b0);

      // Start during RUN must be ignored
      wait_idle8();
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; sub8 = 1'b0;
      start8 = 1'b1;
      q8.push_back(ref8(8'h12, 8'h34, 1'b1, 1'b0));
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a8 = 8'h01;
      b8 = 8'h00;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      chk("busy_mid_run", busy8, 1);
      wait_done8(4, n);
      chk("latency_ignored_start", n, 8);
      @(posedge clk);
      #1;
      chk("busy_after_done", busy8, 0);
      chk("done_after_done", done8, 0);
      repeat (12) @(posedge clk);
      #1;

      // Reset mid-RUN aborts with no done
      a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b0;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", busy8, 0);
      chk("abort_sum", sum8, 0);
      chk("abort_cout", cout8, 0);
      chk("abort_done", done8, 0);
      repeat (12) @(posedge clk);
      #1;
      add8(8'h80, 8'h80, 1'b1, 1'b0);

      // Simultaneous rst and start: start dropped
      wait_idle8();
      rst = 1'b1;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start8 = 1'b0;
      chk("rst_start_busy", busy8, 0);
      @(posedge clk);
      #1;
      chk("rst_start_busy2", busy8, 0);

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         add1(v[2], v[1], v[0]);
      end

`ifdef SERIAL_ADD_SUB_EN
      add8(8'h10, 8'h01, 1'b0, 1'b1);
      add8(8'h01, 8'h02, 1'b0, 1'b1);
`endif

      for (int i = 0; i < 40; i++) begin
         logic s;
         s = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         s = 1'($urandom_range(0, 1));
`endif
         add8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), s);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("q8_drained", q8.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
